// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_pkg;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    RUN    = 3'd3,
    ERR    = 3'd4
  } imem_state_e;

  localparam int          IMEM_DEPTH_LOG2 = 7;
  localparam logic [31:0] NOP_WORD        = 32'h0000_0000;

endpackage

// File: rtl/imem_store.sv
// Instruction store: one synchronous write port and one asynchronous read port.
// Write lands on the clock edge; the read is zero-latency. No backpressure.
module imem_store #(
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_dat,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [31:0]           rd_dat
);

  // Contents survive reset; the loader gates visibility by word count and state.
  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream image loader: holds the core in reset until a full image is stored.
// IR read is combinational; in_ready is a registered state decode (0 in RUN/ERR).
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [31:0] IR_addr,
  output logic [31:0] IR,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [15:0]           MAX_WORDS = 16'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   LEN_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] WC_ONE    = DEPTH_LOG2'(1);

  imem_state_e           state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [DEPTH_LOG2:0]   len_q, len_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [DEPTH_LOG2-1:0] word_cnt_q, word_cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic                  in_ready_q, in_ready_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;

  logic                  xfer;
  logic [15:0]           len_full;
  logic                  wr_en;
  logic [31:0]           wr_dat;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           rd_dat;
  logic                  addr_in_range;

  assign xfer     = in_valid & in_ready_q;
  assign len_full = {len_hi_q, in_data};
  assign wr_dat   = {asm_q, in_data};

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    wr_en      = 1'b0;

    case (state_q)
      LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0 || len_full > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            len_d      = len_full[DEPTH_LOG2:0];
            byte_cnt_d = 2'd0;
            word_cnt_d = '0;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          asm_d      = {asm_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_en      = 1'b1;
            word_cnt_d = word_cnt_q + WC_ONE;
            if ({1'b0, word_cnt_q} == len_q - LEN_ONE) begin
              state_d = RUN;
            end
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // Outputs decode the next state so they change together with the state register.
    in_ready_d   = (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA);
    core_rst_n_d = (state_d == RUN);
    load_done_d  = (state_d == RUN);
    load_err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LEN_HI;
      len_hi_q     <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      asm_q        <= '0;
      in_ready_q   <= 1'b1;
      core_rst_n_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      asm_q        <= asm_d;
      in_ready_q   <= in_ready_d;
      core_rst_n_q <= core_rst_n_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  imem_store #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (word_cnt_q),
    .wr_dat  (wr_dat),
    .rd_addr (rd_idx),
    .rd_dat  (rd_dat)
  );

  // Byte offset bits are dropped; anything above the store's span reads as NOP.
  assign rd_idx        = IR_addr[DEPTH_LOG2+1:2];
  assign addr_in_range = ((IR_addr >> (DEPTH_LOG2 + 2)) == 32'd0);

  assign IR = (state_q == RUN && addr_in_range && ({1'b0, rd_idx} < len_q)) ? rd_dat : NOP_WORD;

  assign in_ready   = in_ready_q;
  assign core_rst_n = core_rst_n_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule
